// File: rtl/i2c_frame_parser.sv
// Parses the I2C slave's master-write byte stream into XOR-checksummed command frames
// and builds the 11-byte response image that the slave returns on the next master read.
module i2c_frame_parser #(
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter logic [7:0] RSP_BYTE    = 8'h5A,
    parameter int         MAX_LEN     = 8,
    parameter int         TIMEOUT_CYC = 50000
) (
    input  logic        clk,
    input  logic        rst_in,
    input  logic        rx_dong_sig,
    input  logic [7:0]  rx_data,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic [3:0]  cmd_len,
    output logic [63:0] cmd_payload,
    output logic        tx_start_sig,
    output logic [87:0] tx_data_buf
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_LEN, S_PAY, S_CSUM} state_t;

    state_t          state_reg;
    logic [7:0]      code_reg;
    logic [7:0]      len_reg;
    logic [7:0]      xor_reg;
    logic [7:0]      frame_cnt_reg;
    logic [3:0]      idx_reg;
    logic [63:0]     pay_reg;
    logic [TW-1:0]   tmo_reg;
    logic            tmo_expire;
    logic [7:0]      frame_cnt_next;

    // tmo_reg counts strobe-free cycles since the last strobe; the TIMEOUT_CYC-th such
    // cycle is the expiry cycle, and a strobe landing there takes priority.
    assign tmo_expire     = (state_reg != S_IDLE) && !rx_dong_sig &&
                            (tmo_reg == TW'(TIMEOUT_CYC - 1));
    assign frame_cnt_next = frame_cnt_reg + 8'd1;

    function automatic logic [87:0] rsp(input logic [7:0] code, input logic [7:0] status,
                                        input logic [7:0] cnt, input logic [7:0] len,
                                        input logic [47:0] pay);
        return {pay, len, cnt, status, code, RSP_BYTE};
    endfunction

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_reg     <= S_IDLE;
            code_reg      <= '0;
            len_reg       <= '0;
            xor_reg       <= '0;
            frame_cnt_reg <= '0;
            idx_reg       <= '0;
            pay_reg       <= '0;
            tmo_reg       <= '0;
            cmd_valid     <= 1'b0;
            cmd_code      <= '0;
            cmd_len       <= '0;
            cmd_payload   <= '0;
            tx_start_sig  <= 1'b0;
            tx_data_buf   <= '0;
        end else begin
            cmd_valid    <= 1'b0;
            tx_start_sig <= 1'b0;

            if (state_reg == S_IDLE || rx_dong_sig) begin
                tmo_reg <= '0;
            end else begin
                tmo_reg <= tmo_reg + TW'(1);
            end

            if (tmo_expire) begin
                tx_data_buf  <= rsp(code_reg, 8'd3, frame_cnt_reg, len_reg, 48'h0);
                tx_start_sig <= 1'b1;
                state_reg    <= S_IDLE;
            end else if (rx_dong_sig) begin
                case (state_reg)
                    S_IDLE: begin
                        if (rx_data == SYNC_BYTE) begin
                            // Clear per-frame fields so a timeout reports 0 for unseen bytes
                            code_reg  <= '0;
                            len_reg   <= '0;
                            pay_reg   <= '0;
                            state_reg <= S_CMD;
                        end
                    end
                    S_CMD: begin
                        code_reg  <= rx_data;
                        xor_reg   <= rx_data;
                        state_reg <= S_LEN;
                    end
                    S_LEN: begin
                        len_reg <= rx_data;
                        xor_reg <= xor_reg ^ rx_data;
                        idx_reg <= '0;
                        if (rx_data > 8'(MAX_LEN)) begin
                            tx_data_buf  <= rsp(code_reg, 8'd2, frame_cnt_reg, rx_data, 48'h0);
                            tx_start_sig <= 1'b1;
                            state_reg    <= S_IDLE;
                        end else if (rx_data == 8'd0) begin
                            state_reg <= S_CSUM;
                        end else begin
                            state_reg <= S_PAY;
                        end
                    end
                    S_PAY: begin
                        pay_reg[{idx_reg[2:0], 3'b000} +: 8] <= rx_data;
                        xor_reg <= xor_reg ^ rx_data;
                        idx_reg <= idx_reg + 4'd1;
                        if ((idx_reg + 4'd1) == len_reg[3:0]) begin
                            state_reg <= S_CSUM;
                        end
                    end
                    S_CSUM: begin
                        if (rx_data == xor_reg) begin
                            cmd_code      <= code_reg;
                            cmd_len       <= len_reg[3:0];
                            cmd_payload   <= pay_reg;
                            cmd_valid     <= 1'b1;
                            frame_cnt_reg <= frame_cnt_next;
                            tx_data_buf   <= rsp(code_reg, 8'd0, frame_cnt_next, len_reg,
                                                 pay_reg[47:0]);
                        end else begin
                            tx_data_buf <= rsp(code_reg, 8'd1, frame_cnt_reg, len_reg, 48'h0);
                        end
                        tx_start_sig <= 1'b1;
                        state_reg    <= S_IDLE;
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_frame_parser.sv
// Directed-vector bench: a byte-queue frame model checked against the parser every cycle,
// plus literal expectations at the points where each response must have just appeared.
module tb_i2c_frame_parser;
    localparam int T = 40;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic        rx_dong_sig = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        cmd_valid;
    logic [7:0]  cmd_code;
    logic [3:0]  cmd_len;
    logic [63:0] cmd_payload;
    logic        tx_start_sig;
    logic [87:0] tx_data_buf;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    i2c_frame_parser #(.TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst_in(rst_in), .rx_dong_sig(rx_dong_sig), .rx_data(rx_data),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_len(cmd_len),
        .cmd_payload(cmd_payload), .tx_start_sig(tx_start_sig), .tx_data_buf(tx_data_buf)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [87:0] act, logic [87:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endfunction

    // ---------------- behavioural model ----------------
    bit          in_frame = 1'b0;
    logic [7:0]  q[$];
    int          gap = 0;
    logic [7:0]  fcnt = 8'h00;
    logic        m_valid = 1'b0, m_start = 1'b0;
    logic [7:0]  m_code = 8'h00;
    logic [3:0]  m_len = 4'h0;
    logic [63:0] m_pay = 64'h0;
    logic [87:0] m_buf = 88'h0;

    task automatic respond(input logic [7:0] status, input logic [7:0] c, input logic [7:0] l,
                           input logic [63:0] pay);
        logic [7:0] b[11];
        b[0] = 8'h5A; b[1] = c; b[2] = status; b[3] = fcnt; b[4] = l;
        for (int k = 0; k < 6; k++) b[5+k] = pay[8*k +: 8];
        for (int k = 0; k < 11; k++) m_buf[8*k +: 8] = b[k];
        m_start = 1'b1;
        in_frame = 1'b0;
    endtask

    task automatic judge();
        logic [7:0]  x;
        logic [63:0] p;
        if (q.size() == 2 && q[1] > 8) begin
            respond(8'd2, q[0], q[1], 64'h0);
        end else if (q.size() >= 2 && q.size() == int'(q[1]) + 3) begin
            x = 8'h00;
            p = 64'h0;
            for (int k = 0; k < q.size() - 1; k++) x ^= q[k];
            for (int k = 0; k < int'(q[1]); k++) p[8*k +: 8] = q[2+k];
            if (x == q[q.size()-1]) begin
                fcnt++;
                m_code = q[0]; m_len = q[1][3:0]; m_pay = p; m_valid = 1'b1;
                respond(8'd0, q[0], q[1], p);
            end else begin
                respond(8'd1, q[0], q[1], 64'h0);
            end
        end
    endtask

    always @(posedge clk) begin
        m_valid = 1'b0;
        m_start = 1'b0;
        if (rst_in) begin
            in_frame = 1'b0; q.delete(); gap = 0; fcnt = 8'h00;
            m_code = 8'h00; m_len = 4'h0; m_pay = 64'h0; m_buf = 88'h0;
        end else if (rx_dong_sig) begin
            gap = 0;
            if (!in_frame) begin
                if (rx_data == 8'hA5) begin
                    in_frame = 1'b1;
                    q.delete();
                end
            end else begin
                q.push_back(rx_data);
                judge();
            end
        end else if (in_frame) begin
            gap++;
            if (gap == T)
                respond(8'd3, (q.size() >= 1) ? q[0] : 8'h00, (q.size() >= 2) ? q[1] : 8'h00,
                        64'h0);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmd_valid", 88'(cmd_valid), 88'(m_valid));
            chk("tx_start_sig", 88'(tx_start_sig), 88'(m_start));
            chk("cmd_code", 88'(cmd_code), 88'(m_code));
            chk("cmd_len", 88'(cmd_len), 88'(m_len));
            chk("cmd_payload", 88'(cmd_payload), 88'(m_pay));
            chk("tx_data_buf", tx_data_buf, m_buf);
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [7:0] b);
        rx_dong_sig = 1'b1;
        rx_data = b;
        @(posedge clk);
        #1;
        rx_dong_sig = 1'b0;
        $display("byte %h sent @%0t", b, $time);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic good_frame();
        send(8'hA5); send(8'h10); send(8'h02); send(8'h11); send(8'h22); send(8'h21);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_in = 1'b0;
        chk_en = 1'b1;
        chk("reset buf", tx_data_buf, 88'h0);
        chk("reset pulses", 88'({cmd_valid, tx_start_sig}), 88'h0);

        good_frame();
        chk("good valid", 88'({cmd_valid, tx_start_sig}), 88'h3);
        chk("good code", 88'(cmd_code), 88'h10);
        chk("good len", 88'(cmd_len), 88'h2);
        chk("good payload", 88'(cmd_payload), 88'h2211);
        chk("good buf", tx_data_buf, 88'h00000000_2211_02_01_00_10_5A);
        idle(3);

        send(8'hA5); send(8'h10); send(8'h02); send(8'h11); send(8'h22); send(8'h20);
        chk("badcsum pulses", 88'({cmd_valid, tx_start_sig}), 88'h1);
        chk("badcsum buf", tx_data_buf, 88'h000000000000_02_01_01_10_5A);
        idle(2);

        send(8'hA5); send(8'h20); send(8'h09);
        chk("lenerr buf", tx_data_buf, 88'h000000000000_09_01_02_20_5A);
        send(8'hA5); send(8'h20); send(8'h00); send(8'h20);
        chk("len0 valid", 88'(cmd_valid), 88'h1);
        chk("len0 buf", tx_data_buf, 88'h000000000000_00_02_00_20_5A);
        idle(2);

        send(8'hA5); send(8'h30);
        idle(T);
        chk("timeout pulse", 88'(tx_start_sig), 88'h1);
        chk("timeout buf", tx_data_buf, 88'h000000000000_00_02_03_30_5A);
        idle(2);

        send(8'hA5); send(8'h30);
        idle(T - 1);
        send(8'h00);
        chk("expiry strobe no pulse", 88'(tx_start_sig), 88'h0);
        send(8'h30);
        chk("expiry frame buf", tx_data_buf, 88'h000000000000_00_03_00_30_5A);
        idle(2);

        send(8'h00); send(8'hFF); send(8'hA5); send(8'h40); send(8'h01); send(8'hAA);
        send(8'hEB);
        chk("b2b payload", 88'(cmd_payload), 88'hAA);
        chk("b2b buf", tx_data_buf, 88'h0000000000AA_01_04_00_40_5A);
        idle(2);

        send(8'hA5); send(8'h10);
        rst_in = 1'b1;
        @(posedge clk);
        #1;
        rst_in = 1'b0;
        chk("midreset buf", tx_data_buf, 88'h0);
        chk("midreset cmd", 88'({cmd_code, cmd_len, cmd_payload}), 88'h0);
        chk("midreset pulses", 88'({cmd_valid, tx_start_sig}), 88'h0);

        good_frame();
        chk("after reset buf", tx_data_buf, 88'h00000000_2211_02_01_00_10_5A);
        for (int i = 1; i < 256; i++) good_frame();
        chk("wrap buf", tx_data_buf, 88'h00000000_2211_02_00_00_10_5A);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
